// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes and FSM state encoding for the phase-1 datapath ALU
//               shift/rotate engine; shared with the ALU top-level decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // 3-bit shift/rotate opcodes; 101..111 are pass-through
  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;

  // Engine state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Any opcode at or above OP_PASS leaves the operand untouched
  function automatic logic is_pass(input logic [2:0] op);
    return (op >= OP_PASS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational one-bit shift/rotate step (acc, op) -> next acc.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_acc
);

  // Single-position move selected by opcode; unknown codes hold the value
  always_comb begin
    o_acc = i_acc;
    case (i_op)
      OP_SHR:  o_acc = {1'b0, i_acc[WIDTH-1:1]};
      OP_SHRA: o_acc = {i_acc[WIDTH-1], i_acc[WIDTH-1:1]};
      OP_SHL:  o_acc = {i_acc[WIDTH-2:0], 1'b0};
      OP_ROR:  o_acc = {i_acc[0], i_acc[WIDTH-1:1]};
      OP_ROL:  o_acc = {i_acc[WIDTH-2:0], i_acc[WIDTH-1]};
      default: o_acc = i_acc;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_seq
// Description : Multi-cycle shift/rotate engine, one bit position per clock,
//               with a start/busy/done handshake toward the Z register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [31:0]      shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_op;
  logic [2:0]       w_op_nxt;
  logic [WIDTH-1:0] w_step;
  logic             w_result_ld;
  logic [CNT_W-1:0] w_shamt_eff;
  logic             w_shamt_unused;

  // Upper shift-amount bits are ignored: the count wraps modulo 2**CNT_W
  assign w_shamt_eff    = shamt[CNT_W-1:0];
  assign w_shamt_unused = ^shamt[31:CNT_W];

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc (r_acc),
    .i_op  (r_op),
    .o_acc (w_step)
  );

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and next-datapath values; start is only looked at in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_acc_nxt   = operand;
          w_cnt_nxt   = w_shamt_eff;
          w_op_nxt    = op;
          w_state_nxt = ((w_shamt_eff == '0) || is_pass(op)) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_acc_nxt = w_step;
        w_cnt_nxt = r_cnt - c_cnt_one;
        if (r_cnt == c_cnt_one) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Result is captured on the edge that enters DONE so it is valid with done
  assign w_result_ld = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_op   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_op  <= w_op_nxt;
      busy  <= (w_state_nxt != ST_IDLE);
      done  <= (w_state_nxt == ST_DONE);
      if (w_result_ld) result <= w_acc_nxt;
    end
  end

endmodule
`default_nettype wire
